// File: rtl/step_seq_counter_if.sv
// rtl/step_seq_counter_if.sv - control and status bundle for the strided lattice counter
interface step_seq_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             dir;
    logic             tc;
    logic             load_err;

    modport master (
        output en, up, mode, load, load_val,
        input  q, dir, tc, load_err
    );

    modport slave (
        input  en, up, mode, load, load_val,
        output q, dir, tc, load_err
    );
endinterface

// File: rtl/step_seq_counter.sv
// rtl/step_seq_counter.sv - bounded strided up/down counter with wrap/saturate/bounce; bounce gated by STEP_CNT_BOUNCE_EN
module step_seq_counter #(
    parameter int WIDTH = 4,
    parameter int START = 1,
    parameter int STEP  = 2,
    parameter int LAST  = 15
) (
    input  logic              clk,
    input  logic              rst,
    step_seq_counter_if.slave bus
);
    localparam int W1 = WIDTH + 1;
    localparam logic [WIDTH:0] START_X = W1'(START);
    localparam logic [WIDTH:0] STEP_X  = W1'(STEP);
    localparam logic [WIDTH:0] LAST_X  = W1'(LAST);
    localparam logic [WIDTH:0] MASK_X  = STEP_X - 1'b1;
    localparam logic [WIDTH:0] BELOW_LAST_X = LAST_X - STEP_X;
    localparam logic [WIDTH:0] ABOVE_START_X = START_X + STEP_X;
    localparam bit DEGEN = (START == LAST);

    logic [WIDTH-1:0] q_r;
    logic             dir_r;
    logic             tc_r;
    logic             load_err_r;

    logic [WIDTH:0] q_x;
    logic [WIDTH:0] up_val;
    logic [WIDTH:0] dn_val;
    logic [WIDTH:0] lv_x;
    logic [WIDTH:0] lv_off;
    logic           load_ok;
    logic           over;
    logic           under;
    logic           bounce_sel;
    logic           sat_sel;
    logic           eff_dir;

    // Extended-width arithmetic so the boundary test never sees a wrapped sum
    assign q_x    = {1'b0, q_r};
    assign up_val = q_x + STEP_X;
    assign dn_val = q_x - STEP_X;
    assign over   = (up_val > LAST_X);
    assign under  = (q_x < ABOVE_START_X) || (dn_val < START_X);

    // A load must land on the lattice: in range and aligned to the stride
    assign lv_x    = {1'b0, bus.load_val};
    assign lv_off  = lv_x - START_X;
    assign load_ok = (lv_x >= START_X) && (lv_x <= LAST_X) && ((lv_off & MASK_X) == '0);

`ifdef STEP_CNT_BOUNCE_EN
    assign bounce_sel = (bus.mode == 2'b10);
`else
    assign bounce_sel = 1'b0;
`endif
    assign sat_sel = (bus.mode == 2'b01);
    assign eff_dir = bounce_sel ? dir_r : bus.up;

    // Counter state: load beats count beats hold; terminal count marks boundary hits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r        <= START_X[WIDTH-1:0];
            dir_r      <= 1'b1;
            tc_r       <= 1'b0;
            load_err_r <= 1'b0;
        end else if (bus.load) begin
            tc_r <= 1'b0;
            if (load_ok) begin
                q_r        <= bus.load_val;
                load_err_r <= 1'b0;
            end else begin
                load_err_r <= 1'b1;
            end
        end else if (bus.en) begin
            load_err_r <= 1'b0;
            if (!bounce_sel) begin
                dir_r <= bus.up;
            end
            if (DEGEN) begin
                tc_r <= 1'b1;
            end else if (eff_dir) begin
                if (!over) begin
                    q_r  <= up_val[WIDTH-1:0];
                    tc_r <= 1'b0;
                end else begin
                    tc_r <= 1'b1;
                    if (bounce_sel) begin
                        q_r   <= BELOW_LAST_X[WIDTH-1:0];
                        dir_r <= 1'b0;
                    end else if (!sat_sel) begin
                        q_r <= START_X[WIDTH-1:0];
                    end
                end
            end else begin
                if (!under) begin
                    q_r  <= dn_val[WIDTH-1:0];
                    tc_r <= 1'b0;
                end else begin
                    tc_r <= 1'b1;
                    if (bounce_sel) begin
                        q_r   <= ABOVE_START_X[WIDTH-1:0];
                        dir_r <= 1'b1;
                    end else if (!sat_sel) begin
                        q_r <= LAST_X[WIDTH-1:0];
                    end
                end
            end
        end else begin
            tc_r       <= 1'b0;
            load_err_r <= 1'b0;
        end
    end

    assign bus.q        = q_r;
    assign bus.dir      = dir_r;
    assign bus.tc       = tc_r;
    assign bus.load_err = load_err_r;
endmodule

// File: tb/tb_step_seq_counter.sv
// tb/tb_step_seq_counter.sv - directed vector bench for step_seq_counter
module tb_step_seq_counter;
`ifdef STEP_CNT_BOUNCE_EN
    localparam bit BNC = 1'b1;
`else
    localparam bit BNC = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    step_seq_counter_if #(.WIDTH(4)) bus ();
    step_seq_counter_if #(.WIDTH(5)) b5 ();

    step_seq_counter #(.WIDTH(4), .START(1), .STEP(2), .LAST(15)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    step_seq_counter #(.WIDTH(5), .START(1), .STEP(2), .LAST(15)) dut5 (
        .clk(clk), .rst(rst), .bus(b5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic [1:0] mode;
        logic [3:0] q;
        logic       dir;
        logic       tc;
        logic       le;
    } vec_t;

    vec_t vecs[64];
    int   nv;

    function void add(input logic ld, input logic [3:0] lv, input logic en, input logic up,
                      input logic [1:0] mode, input logic [3:0] q, input logic dir,
                      input logic tc, input logic le);
        vecs[nv].ld = ld;   vecs[nv].lv = lv;    vecs[nv].en = en;
        vecs[nv].up = up;   vecs[nv].mode = mode;
        vecs[nv].q = q;     vecs[nv].dir = dir;  vecs[nv].tc = tc;  vecs[nv].le = le;
        nv++;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int q, input int dir, input int tc, input int le);
        check({tag, ".q"}, int'(bus.q), q);
        check({tag, ".dir"}, int'(bus.dir), dir);
        check({tag, ".tc"}, int'(bus.tc), tc);
        check({tag, ".load_err"}, int'(bus.load_err), le);
    endtask

    initial begin
        logic bd;
        checks = 0;
        errors = 0;
        nv = 0;
        bd = BNC ? 1'b0 : 1'b1;

        // wrap up from 1 through 15 back to 1
        for (int i = 1; i <= 7; i++) add(0, 0, 1, 1, 2'b00, 4'(1 + 2*i), 1, 0, 0);
        add(0, 0, 1, 1, 2'b00, 1, 1, 1, 0);
        // wrap down from START
        add(0, 0, 1, 0, 2'b00, 15, 0, 1, 0);
        // saturate at LAST, tc held high
        for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 2'b01, 15, 1, 1, 0);
        // load keeps dir
        add(1, 13, 0, 1, 2'b00, 13, 1, 0, 0);
        // bounce (wrap when the feature is absent)
        add(0, 0, 1, 1, 2'b10, 15, 1, 0, 0);
        add(0, 0, 1, 1, 2'b10, BNC ? 4'd13 : 4'd1, bd, 1, 0);
        add(0, 0, 1, 1, 2'b10, BNC ? 4'd11 : 4'd3, bd, 0, 0);
        // load priority and lattice rejection
        add(1, 9, 1, 1, 2'b00, 9, bd, 0, 0);
        add(1, 8, 1, 1, 2'b00, 9, bd, 0, 1);
        add(0, 0, 0, 1, 2'b00, 9, bd, 0, 0);
        add(1, 0, 0, 1, 2'b00, 9, bd, 0, 1);
        add(1, 15, 0, 1, 2'b00, 15, bd, 0, 0);
        // mode 11 wraps
        add(0, 0, 1, 1, 2'b11, 1, 1, 1, 0);
        // saturate at START going down
        add(0, 0, 1, 0, 2'b01, 1, 0, 1, 0);
        add(1, 5, 0, 0, 2'b01, 5, 0, 0, 0);
        // enable gating holds q and dir
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 2'b00, 5, 0, 0, 0);
        add(1, 7, 0, 1, 2'b00, 7, 0, 0, 0);
        add(0, 0, 1, 1, 2'b00, 9, 1, 0, 0);
        add(0, 0, 1, 0, 2'b00, 7, 0, 0, 0);

        rst = 1'b0;
        bus.en = 0; bus.up = 1; bus.mode = 0; bus.load = 0; bus.load_val = 0;
        b5.en = 0;  b5.up = 1;  b5.mode = 0;  b5.load = 0;  b5.load_val = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            bus.load = vecs[i].ld; bus.load_val = vecs[i].lv; bus.en = vecs[i].en;
            bus.up = vecs[i].up;   bus.mode = vecs[i].mode;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), int'(vecs[i].q), int'(vecs[i].dir),
                      int'(vecs[i].tc), int'(vecs[i].le));
        end

        // asynchronous reset mid-count, between edges
        @(negedge clk);
        bus.load = 0; bus.en = 1; bus.up = 1; bus.mode = 2'b00;
        rst = 1'b0;
        #1;
        check_all("async_rst", 1, 1, 0, 0);
        @(posedge clk);
        #1;
        check_all("rst_held", 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst", 3, 1, 0, 0);

        // wider build: value beyond LAST but representable is rejected
        @(negedge clk);
        bus.en = 0;
        b5.load = 1; b5.load_val = 5'd17;
        @(posedge clk);
        #1;
        check("w5_17.q", int'(b5.q), 1);
        check("w5_17.load_err", int'(b5.load_err), 1);
        @(negedge clk);
        b5.load_val = 5'd9;
        @(posedge clk);
        #1;
        check("w5_9.q", int'(b5.q), 9);
        check("w5_9.load_err", int'(b5.load_err), 0);
        @(negedge clk);
        b5.load = 0; b5.en = 1; b5.up = 1;
        @(posedge clk);
        #1;
        check("w5_cnt.q", int'(b5.q), 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/step_seq_counter.md
# step_seq_counter

Parametrised lattice up/down counter and successor to the fixed 4-bit odd-value counter. It steps through the value set START, START+STEP, …, LAST in either direction. It supports three end-of-range modes (wrap, saturate, bounce), count enable, and synchronous parallel load with lattice checking. It is used wherever the design needs a bounded, strided sequence generator with a terminal-count indication.

## Interface
Parameters:
- WIDTH, 4: counter width in bits.
- START, 1: lowest lattice value; reset value.
- STEP, 2: stride. Must be a power of two, ≥1.
- LAST, 15: highest lattice value. Requires START ≤ LAST < 2^WIDTH and (LAST−START) a multiple of STEP.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 counts up, 0 counts down. Ignored in bounce mode.
- mode  in  2  end-of-range mode: 00 wrap, 01 saturate, 10 bounce, 11 treated as wrap.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  current count.
- dir  out  1  registered effective direction.
- tc  out  1  registered terminal-count pulse.
- load_err  out  1  registered one-cycle flag for a rejected load.

## Operation
- Reset (rst=0, asynchronous): q=START, dir=1, tc=0, load_err=0. These values are held while rst=0.
- Priority per edge: load > en > hold.
- Load acceptance: load_val is accepted when START ≤ load_val ≤ LAST and the low log2(STEP) bits of (load_val−START) are zero.
  - Accepted: q←load_val, load_err←0.
  - Rejected: q holds, load_err←1. No count occurs that cycle even if en=1.
  - dir is unchanged by any load. tc←0 on any load cycle.
- Count (en=1, load=0): effective direction is dir in bounce mode and up otherwise. In non-bounce modes, dir←up.
  - Interior value: q←q±STEP.
  - Wrap, at the boundary in the travel direction: LAST→START going up, START→LAST going down.
  - Saturate, at the boundary: q holds.
  - Bounce, at LAST with dir=1: q←LAST−STEP, dir←0. At START with dir=0: q←START+STEP, dir←1.
- tc←1 in the cycle after any enabled count edge where q was at the boundary in the travel direction (a wrap, a saturation hold, or a bounce reversal). Otherwise tc←0.
- en=0 and load=0: q and dir hold, tc←0, load_err←0.
- Degenerate case START==LAST: q holds in every mode, and tc←1 on every enabled edge.
- Mode change takes effect on the next edge. Entering bounce mode keeps the current dir.

## Timing
- All outputs are registered. q, dir, tc, and load_err update one edge after their cause and have zero combinational input-to-output paths.
- tc and load_err are single-cycle pulses unless the triggering condition repeats on consecutive edges (for example, continuous saturation).
- Reset asserted mid-count overrides everything immediately. The first count after release happens on the first posedge with rst=1 and en=1.
- Arithmetic is done in WIDTH+1 bits, so q±STEP never aliases before the boundary compare.

## Configuration
- STEP_CNT_BOUNCE_EN defined: bounce mode (mode=10) is implemented as described.
- STEP_CNT_BOUNCE_EN undefined: mode=10 behaves exactly as wrap. dir always follows up on enabled cycles, and no bounce reversal logic is synthesised.

## Test plan
- Reset: count to q=7, pull rst low between edges → q=1, dir=1, tc=0 immediately. After release with en=1, q=3 on the first edge.
- Wrap up: mode=00, up=1, en=1 from q=1 for 8 edges → q=3,5,…,15,1. tc=1 only in the cycle after the 15→1 edge.
- Wrap down, then saturate: up=0 from q=1 → q=15, tc pulse. Then mode=01, up=1 at q=15 for 3 edges → q stays 15, tc=1 for all 3 cycles.
- Bounce (macro defined): mode=10, dir=1 from q=13 → q=15, 13, 11. dir=0 after the 15→13 edge, with tc=1 once. Same stimulus without the macro → q=15, 1, 3.
- Load: load_val=9 → q=9, load_err=0. Next, load_val=8 with en=1 → q stays 9, load_err=1 for one cycle. Then load_val=17 (WIDTH=5 build) → rejected the same way.
- Enable gating: en=0 for 4 edges at q=5 → q=5 held, tc=0. A load with en=0 still loads.
